// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 word selector with a valid/ready output stage.
// Direct mode picks the channel by Sel; scan mode round-robins over the enabled channels in Mask.
module mux_nto1_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] In,
  input  logic                    InValid,
  input  logic                    Mode,
  input  logic [SEL_W-1:0]        Sel,
  input  logic [NUM_IN-1:0]       Mask,
  input  logic                    OutReady,
  output logic [WIDTH-1:0]        Out,
  output logic                    OutValid,
  output logic [SEL_W-1:0]        OutSel,
  output logic                    OutErr
);

  logic [SEL_W-1:0] scan_ptr;
  logic [SEL_W-1:0] scan_idx;
  logic             scan_found;
  logic [SEL_W-1:0] pick;
  logic [WIDTH-1:0] pick_data;
  logic             sel_oob;
  logic             load;

  // Circular search from scan_ptr; the first hit (smallest offset) wins.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      automatic int               j  = int'(scan_ptr) + i;
      automatic logic [SEL_W-1:0] jj;
      if (j >= NUM_IN) j = j - NUM_IN;
      jj = SEL_W'(j);
      if (!scan_found && Mask[jj]) begin
        scan_found = 1'b1;
        scan_idx   = jj;
      end
    end
  end

  // An out-of-range Sel matches no channel, so the word reads as zero.
  always_comb begin
    pick      = Mode ? scan_idx : Sel;
    sel_oob   = !Mode && (int'(Sel) >= NUM_IN);
    pick_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (SEL_W'(k) == pick) pick_data = In[k*WIDTH +: WIDTH];
    end
  end

  assign load = InValid && (!OutValid || OutReady) && (!Mode || scan_found);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Out      <= '0;
      OutValid <= 1'b0;
      OutSel   <= '0;
      OutErr   <= 1'b0;
      scan_ptr <= '0;
    end else if (load) begin
      Out      <= pick_data;
      OutValid <= 1'b1;
      OutSel   <= pick;
      OutErr   <= sel_oob;
      if (Mode) begin
        scan_ptr <= (scan_idx == SEL_W'(NUM_IN - 1)) ? '0 : scan_idx + 1'b1;
      end
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Bench for mux_nto1_reg: a 16-input and a 12-input instance share stimulus and
// are checked every cycle against a rule-level model plus directed literal expectations.
module tb_mux_nto1_reg;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       chan [16];
  logic [511:0]      in16;
  logic              in_valid;
  logic              mode;
  logic [3:0]        sel;
  logic [15:0]       mask;
  logic              out_ready;

  logic [31:0] out16, out12;
  logic        valid16, valid12;
  logic [3:0]  osel16, osel12;
  logic        err16, err12;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_out   [2];
  logic [3:0]  m_sel   [2];
  logic        m_valid [2];
  logic        m_err   [2];
  int          m_ptr   [2];

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 16; k++) in16[k*32 +: 32] = chan[k];
  end

  mux_nto1_reg #(.WIDTH(32), .NUM_IN(16)) u16 (
    .Clk(clk), .Reset(reset), .In(in16), .InValid(in_valid), .Mode(mode),
    .Sel(sel), .Mask(mask), .OutReady(out_ready),
    .Out(out16), .OutValid(valid16), .OutSel(osel16), .OutErr(err16)
  );

  mux_nto1_reg #(.WIDTH(32), .NUM_IN(12)) u12 (
    .Clk(clk), .Reset(reset), .In(in16[383:0]), .InValid(in_valid), .Mode(mode),
    .Sel(sel), .Mask(mask[11:0]), .OutReady(out_ready),
    .Out(out12), .OutValid(valid12), .OutSel(osel12), .OutErr(err12)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one word slot per instance, updated from the load/drain rules each edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_out[d] <= '0; m_sel[d] <= '0; m_valid[d] <= 1'b0; m_err[d] <= 1'b0; m_ptr[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        automatic int          n  = (d == 1) ? 12 : 16;
        automatic logic [15:0] mk = (d == 1) ? (mask & 16'h0FFF) : mask;
        automatic bit          ld = in_valid && (!m_valid[d] || out_ready) && (!mode || mk != 0);
        automatic int          c  = -1;
        if (ld) begin
          m_valid[d] <= 1'b1;
          if (!mode) begin
            m_sel[d] <= sel;
            m_err[d] <= (int'(sel) >= n);
            m_out[d] <= (int'(sel) < n) ? chan[sel] : 32'h0;
          end else begin
            for (int off = 0; off < n; off++) begin
              if (c < 0 && mk[(m_ptr[d] + off) % n]) c = (m_ptr[d] + off) % n;
            end
            m_out[d] <= chan[c];
            m_sel[d] <= 4'(c);
            m_err[d] <= 1'b0;
            m_ptr[d] <= (c + 1) % n;
          end
        end else if (out_ready) begin
          m_valid[d] <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison; held values are compared too, so they must stay stable.
  always @(negedge clk) begin
    if (!reset) begin
      check("m16_valid", 64'(valid16), 64'(m_valid[0]));
      check("m16_out",   64'(out16),   64'(m_out[0]));
      check("m16_sel",   64'(osel16),  64'(m_sel[0]));
      check("m16_err",   64'(err16),   64'(m_err[0]));
      check("m12_valid", 64'(valid12), 64'(m_valid[1]));
      check("m12_out",   64'(out12),   64'(m_out[1]));
      check("m12_sel",   64'(osel12),  64'(m_sel[1]));
      check("m12_err",   64'(err12),   64'(m_err[1]));
    end
  end

  initial begin
    int scan_exp [5];
    scan_exp = '{0, 2, 15, 0, 2};
    for (int k = 0; k < 16; k++) chan[k] = 32'h1000 + k;
    reset = 1'b1; in_valid = 1'b0; mode = 1'b0; sel = '0; mask = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(valid16), 64'(0));
    check("rst_out",   64'(out16),   64'(0));
    check("rst_sel",   64'(osel16),  64'(0));
    check("rst_err",   64'(err16),   64'(0));
    reset = 1'b0;

    // direct sweep, one word per cycle
    in_valid = 1'b1; out_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      @(negedge clk);
      check("sweep_out",   64'(out16),   64'(32'h1000 + s));
      check("sweep_valid", 64'(valid16), 64'(1));
      check("sweep_err",   64'(err16),   64'(0));
    end

    // stall holds the word while Sel moves
    sel = 4'd3;
    @(negedge clk);
    out_ready = 1'b0; sel = 4'd7;
    repeat (4) begin
      @(negedge clk);
      check("stall_out", 64'(out16),  64'(32'h1003));
      check("stall_sel", 64'(osel16), 64'(3));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("unstall_out", 64'(out16), 64'(32'h1007));

    in_valid = 1'b0;
    @(negedge clk);
    check("drain_valid", 64'(valid16), 64'(0));
    check("drain_hold",  64'(out16),   64'(32'h1007));

    // scan with skip and wrap
    mode = 1'b1; mask = 16'h8005; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("scan_sel", 64'(osel16), 64'(scan_exp[i]));
    end

    // empty mask: nothing loads, pointer (now 3) keeps its place
    mask = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      check("empty_valid", 64'(valid16), 64'(0));
    end
    mask = 16'h0010;
    @(negedge clk);
    check("after_empty_sel", 64'(osel16), 64'(4));

    // mask changes while stalled do not disturb the held word
    out_ready = 1'b0; mask = 16'h0003;
    repeat (2) begin
      @(negedge clk);
      check("stall_mask_sel", 64'(osel16), 64'(4));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("scan_wrap_sel", 64'(osel16), 64'(0));

    // pointer survives a mode round trip (it is now 1)
    mode = 1'b0; sel = 4'd9;
    @(negedge clk);
    check("direct9_out", 64'(out16), 64'(32'h1009));
    mode = 1'b1; mask = 16'hFFFF;
    @(negedge clk);
    check("ptr_kept_sel", 64'(osel16), 64'(1));

    // out-of-range select on the 12-input instance
    mode = 1'b0; sel = 4'd13;
    @(negedge clk);
    check("oob_out", 64'(out12),  64'(0));
    check("oob_sel", 64'(osel12), 64'(13));
    check("oob_err", 64'(err12),  64'(1));
    sel = 4'd11;
    @(negedge clk);
    check("last_out", 64'(out12), 64'(32'h100B));
    check("last_err", 64'(err12), 64'(0));

    // asynchronous reset between edges
    chan[5] = 32'hDEADBEEF; sel = 4'd5;
    @(negedge clk);
    check("pre_rst_out", 64'(out16), 64'(32'hDEADBEEF));
    #2 reset = 1'b1;
    #1;
    check("async_out",   64'(out16),   64'(0));
    check("async_valid", 64'(valid16), 64'(0));
    check("async_sel",   64'(osel16),  64'(0));
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(valid16), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_nto1_reg.md
Name: mux_nto1_reg

Overview:
Parametrised, registered N-to-1 word multiplexer. It is the pipelined successor to the combinational 32-bit selectors in the datapath (forwarding, writeback and debug-bus selection). It adds a valid/ready output stage and a masked round-robin scan mode, so one consumer can drain several producers without external sequencing. It sits between a set of word sources and a single registered sink.

Parameters:
WIDTH, 32, bits per data word
NUM_IN, 16, number of input channels, 2..32, need not be a power of two
SEL_W, $clog2(NUM_IN), select and pointer width (derived; do not override)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
In  input  NUM_IN*WIDTH  packed inputs; channel k = In[k*WIDTH +: WIDTH]
InValid  input  1  sources present a word this cycle
Mode  input  1  0 = direct (Sel chooses the channel), 1 = scan (internal round-robin)
Sel  input  SEL_W  channel index, used in direct mode only
Mask  input  NUM_IN  per-channel enable, used in scan mode only
OutReady  input  1  sink accepts Out this cycle
Out  output  WIDTH  registered selected word
OutValid  output  1  Out holds a word not yet taken
OutSel  output  SEL_W  channel index that produced Out
OutErr  output  1  Out came from an out-of-range Sel

Behaviour:
- Reset: Out=0, OutValid=0, OutSel=0, OutErr=0, ScanPtr=0. Reset is asynchronous and takes effect immediately, including mid-transfer; any pending word is discarded.
- Definitions:
  - load = InValid && (!OutValid || OutReady) && (Mode==0 || Mask!=0)
  - drain = OutValid && OutReady
- Latency: 1 cycle. A word presented at edge t appears on Out after edge t with OutValid=1.
- Throughput: 1 word per cycle. If load and drain happen in the same cycle, the new word replaces the old one and OutValid stays 1.
- Drain without load: OutValid <= 0. Out and OutSel keep their old values; they are don't-care but must be stable.
- Stall (OutValid && !OutReady): Out, OutSel and OutErr hold. In and Sel are ignored; no word is lost or overwritten.
- Direct mode (load, Mode=0):
  - Sel < NUM_IN: Out <= channel Sel, OutSel <= Sel, OutErr <= 0.
  - Sel >= NUM_IN (only possible when NUM_IN is not a power of two): Out <= 0, OutSel <= Sel, OutErr <= 1.
  - ScanPtr does not change.
- Scan mode (load, Mode=1):
  - Chosen channel c = first index with Mask[c]=1, searching circularly from ScanPtr upward (ScanPtr, ScanPtr+1, ..., NUM_IN-1, 0, ...).
  - Out <= channel c, OutSel <= c, OutErr <= 0.
  - ScanPtr <= c+1, or 0 if c = NUM_IN-1 (wrap-around).
- Scan mode with Mask=0: no load and OutValid does not rise. A held word may still drain.
- Scan mode with a single mask bit: that channel is chosen on every load.
- Mask is sampled only at load. Changing it while stalled does not affect the held word.
- Mode switches take effect on the next load. ScanPtr is retained across Mode changes and is cleared only by Reset.
- No internal state machine beyond the OutValid flag and ScanPtr. Logic is combinational select plus a single register stage. Sel, Mask and In must be stable at the clock edge.

Test Plan:
- Reset mid-stream: OutValid=1 with Out=0xDEADBEEF, assert Reset between clock edges -> Out=0, OutValid=0, OutSel=0 immediately, before the next edge.
- Direct mode, NUM_IN=16, channel k = 0x1000+k, OutReady=1, Sel sweeps 0..15 over consecutive cycles -> Out equals 0x1000..0x100F one cycle later, OutValid=1 continuously, OutErr=0.
- Stall: direct mode, Sel=3, OutReady=0 for 4 cycles while Sel changes to 7 -> Out stays 0x1003 with OutSel=3. Then OutReady=1 for one cycle -> the next Out is 0x1007.
- Scan with wrap and skip: NUM_IN=16, Mask=0x8005, OutReady=1, InValid=1 for 5 cycles -> OutSel sequence 0,2,15,0,2.
- Empty mask: Mode=1, Mask=0, InValid=1 -> OutValid stays 0 and ScanPtr is unchanged. Then set Mask=0x0010 -> OutSel=4 on the next cycle.
- Non-power-of-two: NUM_IN=12, direct mode, Sel=13 -> Out=0, OutSel=13, OutErr=1. Then Sel=11 -> channel 11 is output with OutErr=0.
